// File: rtl/char_buffer_pkg.sv
// char_buffer_pkg: shared definitions for the text character buffer.
// Engine state encoding, default screen geometry and the depth helper.
package char_buffer_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_COLS   = 80;
    localparam int DEF_ROWS   = 30;
    localparam int DEF_ADDR_W = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        SC_RD   = 3'd2,
        SC_WR   = 3'd3,
        SC_FILL = 3'd4,
        DONE    = 3'd5
    } state_e;

    function automatic int calc_depth(input int cols, input int rows);
        return cols * rows;
    endfunction

endpackage

// File: rtl/char_buffer_mem.sv
// char_buffer_mem: single-port synchronous RAM, one-cycle read latency.
// Ports: i_clk, i_en (access), i_we (1=write), i_addr, i_wdata, o_rdata.
// Kept separate so it can be swapped for a vendor RAM primitive.
module char_buffer_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2400,
    parameter int IDX_W  = 12
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/char_buffer_ctrl.sv
// char_buffer_ctrl: COLS*ROWS character buffer with a three-way port
// arbiter (video read > host write > clear/scroll engine).
// Ports: i_clk, i_reset (sync, active-low); video i_vid_req/i_vid_addr
// -> o_vid_data/o_vid_valid; host i_wr_valid/i_wr_addr/i_wr_data ->
// o_wr_ready; engine i_cmd_clear/i_cmd_scroll/i_fill_char -> o_busy/o_done.
// Macro CHARBUF_SCROLL_EN adds the scroll-up engine; without it
// i_cmd_scroll is ignored.
module char_buffer_ctrl
    import char_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic [DATA_W-1:0] o_vid_data,
    output logic              o_vid_valid,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_cmd_clear,
    input  logic              i_cmd_scroll,
    input  logic [DATA_W-1:0] i_fill_char,
    output logic              o_busy,
    output logic              o_done
);

    localparam int DEPTH = calc_depth(COLS, ROWS);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**ADDR_W does not truncate to zero.
    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);
`ifdef CHARBUF_SCROLL_EN
    localparam logic [ADDR_W-1:0] L_COLS    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] L_SC_LAST = ADDR_W'(DEPTH - COLS - 1);
    localparam logic [ADDR_W-1:0] L_SC_FILL = ADDR_W'(DEPTH - COLS);
`endif

    if (DEPTH > (2 ** ADDR_W)) begin : g_depth_chk
        $error("char_buffer_ctrl: COLS*ROWS exceeds 2**ADDR_W");
    end

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < L_DEPTH;
    endfunction

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] w_fill_nxt;

    logic              w_port_free;
    logic              w_wr_fire;
    logic              w_eng_go;
    logic              w_eng_we;
    logic [IDX_W-1:0]  w_eng_idx;
    logic [DATA_W-1:0] w_eng_wdata;

    logic              w_mem_en;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_idx;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_rdata;

    logic              r_vid_valid;
    logic              r_vid_oor;
    logic [DATA_W-1:0] r_vid_hold;

    // Reset also closes the port so nothing touches memory in that cycle.
    assign w_port_free = i_reset & ~i_vid_req;
    assign o_wr_ready  = (r_state == IDLE) & w_port_free;
    assign w_wr_fire   = i_wr_valid & o_wr_ready;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);

`ifdef CHARBUF_SCROLL_EN
    logic              r_rd_pend;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] w_sc_data;

    // RAM output is only valid the cycle after the read, so the first
    // SC_WR cycle bypasses the holding register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= (r_state == SC_RD) & w_port_free;
        end
        if (r_rd_pend) begin
            r_hold <= w_rdata;
        end
    end

    assign w_sc_data = r_rd_pend ? w_rdata : r_hold;
`else
    logic w_unused_scroll;
    assign w_unused_scroll = i_cmd_scroll;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_fill_nxt  = r_fill;
        w_eng_go    = 1'b0;
        w_eng_we    = 1'b1;
        w_eng_idx   = IDX_W'(r_addr);
        w_eng_wdata = r_fill;
        unique case (r_state)
            IDLE: begin
                if (i_cmd_clear) begin
                    w_state_nxt = CLEAR;
                    w_addr_nxt  = '0;
                    w_fill_nxt  = i_fill_char;
                end
`ifdef CHARBUF_SCROLL_EN
                else if (i_cmd_scroll) begin
                    w_state_nxt = (ROWS > 1) ? SC_RD : SC_FILL;
                    w_addr_nxt  = '0;
                    w_fill_nxt  = i_fill_char;
                end
`endif
            end
            CLEAR: begin
                w_eng_go = w_port_free;
                if (w_port_free) begin
                    if (r_addr == L_LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
            end
`ifdef CHARBUF_SCROLL_EN
            SC_RD: begin
                w_eng_go  = w_port_free;
                w_eng_we  = 1'b0;
                w_eng_idx = IDX_W'(r_addr + L_COLS);
                if (w_port_free) begin
                    w_state_nxt = SC_WR;
                end
            end
            SC_WR: begin
                w_eng_go    = w_port_free;
                w_eng_wdata = w_sc_data;
                if (w_port_free) begin
                    if (r_addr < L_SC_LAST) begin
                        w_addr_nxt  = r_addr + 1'b1;
                        w_state_nxt = SC_RD;
                    end else begin
                        w_addr_nxt  = L_SC_FILL;
                        w_state_nxt = SC_FILL;
                    end
                end
            end
            SC_FILL: begin
                w_eng_go = w_port_free;
                if (w_port_free) begin
                    if (r_addr == L_LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Out-of-range host writes and video reads simply never enable the RAM.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_idx   = IDX_W'(i_vid_addr);
        w_mem_wdata = i_wr_data;
        if (i_vid_req) begin
            w_mem_en = in_range(i_vid_addr);
        end else if (w_wr_fire) begin
            w_mem_en  = in_range(i_wr_addr);
            w_mem_we  = 1'b1;
            w_mem_idx = IDX_W'(i_wr_addr);
        end else if (w_eng_go) begin
            w_mem_en    = 1'b1;
            w_mem_we    = w_eng_we;
            w_mem_idx   = w_eng_idx;
            w_mem_wdata = w_eng_wdata;
        end
    end

    char_buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_idx),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_rdata)
    );

    // RAM output also moves on engine reads, so the last video value is
    // kept separately and replayed while o_vid_valid is low.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_vid_valid <= 1'b0;
            r_vid_oor   <= 1'b0;
            r_vid_hold  <= '0;
        end else begin
            r_vid_valid <= i_vid_req;
            r_vid_oor   <= ~in_range(i_vid_addr);
            r_vid_hold  <= o_vid_data;
        end
    end

    assign o_vid_valid = r_vid_valid;
    assign o_vid_data  = !r_vid_valid ? r_vid_hold :
                         r_vid_oor    ? '0 : w_rdata;

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// tb_char_buffer_ctrl: directed plus random stimulus for char_buffer_ctrl
// (COLS=4, ROWS=2), checked every cycle against a transaction-level model.
module tb_char_buffer_ctrl;

    localparam int DW    = 8;
    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int AW    = 4;
    localparam int DEPTH = COLS * ROWS;
`ifdef CHARBUF_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cmd_clear;
    logic          cmd_scroll;
    logic [DW-1:0] fill_char;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    char_buffer_ctrl #(
        .DATA_W (DW),
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (AW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_vid_req    (vid_req),
        .i_vid_addr   (vid_addr),
        .o_vid_data   (vid_data),
        .o_vid_valid  (vid_valid),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_cmd_clear  (cmd_clear),
        .i_cmd_scroll (cmd_scroll),
        .i_fill_char  (fill_char),
        .o_busy       (busy),
        .o_done       (done)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: memory array plus a queue of pending engine operations,
    // one popped per cycle the video port is idle.
    typedef struct {
        int kind;
        int addr;
    } op_t;

    op_t           ops[$];
    op_t           m_op;
    logic [DW-1:0] m_mem[DEPTH];
    bit            m_kn[DEPTH];
    int            m_phase = 0;
    logic [DW-1:0] m_fill = '0;
    logic [DW-1:0] m_hold = '0;
    bit            m_hold_kn = 1'b0;
    bit            m_vvalid = 1'b0;
    logic [DW-1:0] m_vdata = '0;
    bit            m_vkn = 1'b1;

    always @(posedge clk) begin
        if (!reset) begin
            m_phase  = 0;
            ops.delete();
            m_vvalid = 1'b0;
            m_vdata  = '0;
            m_vkn    = 1'b1;
        end else begin
            m_vvalid = vid_req;
            if (vid_req) begin
                if (int'(vid_addr) < DEPTH) begin
                    m_vdata = m_mem[int'(vid_addr)];
                    m_vkn   = m_kn[int'(vid_addr)];
                end else begin
                    m_vdata = '0;
                    m_vkn   = 1'b1;
                end
            end
            case (m_phase)
                0: begin
                    if (wr_valid && !vid_req && int'(wr_addr) < DEPTH) begin
                        m_mem[int'(wr_addr)] = wr_data;
                        m_kn[int'(wr_addr)]  = 1'b1;
                    end
                    if (cmd_clear) begin
                        m_fill = fill_char;
                        for (int a = 0; a < DEPTH; a++) ops.push_back('{2, a});
                        m_phase = 1;
                    end else if (SCROLL && cmd_scroll) begin
                        m_fill = fill_char;
                        for (int a = 0; a < DEPTH - COLS; a++) begin
                            ops.push_back('{0, a + COLS});
                            ops.push_back('{1, a});
                        end
                        for (int a = DEPTH - COLS; a < DEPTH; a++)
                            ops.push_back('{2, a});
                        m_phase = 1;
                    end
                end
                1: begin
                    if (!vid_req) begin
                        m_op = ops.pop_front();
                        case (m_op.kind)
                            0: begin
                                m_hold    = m_mem[m_op.addr];
                                m_hold_kn = m_kn[m_op.addr];
                            end
                            1: begin
                                m_mem[m_op.addr] = m_hold;
                                m_kn[m_op.addr]  = m_hold_kn;
                            end
                            default: begin
                                m_mem[m_op.addr] = m_fill;
                                m_kn[m_op.addr]  = 1'b1;
                            end
                        endcase
                        if (ops.size() == 0) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_phase == 2);
            chk("vid_valid", vid_valid, m_vvalid);
            chk("wr_ready", wr_ready, reset && m_phase == 0 && !vid_req);
            if (m_vkn) chk("vid_data", vid_data, m_vdata);
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input int d);
        bit got;
        got = 1'b0;
        wr_addr  = AW'(a);
        wr_data  = DW'(d);
        wr_valid = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (wr_ready) begin
                got = 1'b1;
                tick();
                break;
            end
            tick();
        end
        wr_valid = 1'b0;
        chk("write_accept", got, 1);
    endtask

    task automatic vid_read(input string name, input int a, input int exp);
        vid_addr = AW'(a);
        vid_req  = 1'b1;
        tick();
        vid_req = 1'b0;
        #1;
        chk({name, "_valid"}, vid_valid, 1);
        chk(name, vid_data, exp);
    endtask

    task automatic wait_idle(input bit toggle, output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 300; i++) begin
            if (toggle) begin
                vid_req  = ~vid_req;
                vid_addr = AW'($urandom_range(0, 15));
            end
            tick();
            n++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        vid_req = 1'b0;
        chk("engine_finish", ok, 1);
    endtask

    task automatic preload(input int base);
        for (int i = 0; i < DEPTH; i++) host_write(i, base + i);
    endtask

    task automatic start_cmd(input bit clr, input bit scr, input int f);
        cmd_clear  = clr;
        cmd_scroll = scr;
        fill_char  = DW'(f);
        tick();
        cmd_clear  = 1'b0;
        cmd_scroll = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int d0;
        int exp;
        reset = 1'b0;
        vid_req = 1'b0;
        vid_addr = '0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        cmd_clear = 1'b0;
        cmd_scroll = 1'b0;
        fill_char = '0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        wr_valid = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_wr_ready", wr_ready, 0);
        wr_valid = 1'b0;
        reset = 1'b1;
        tick();

        preload('h00);
        host_write(5, 'h41);
        vid_read("s1_read", 5, 'h41);

        vid_req  = 1'b1;
        vid_addr = AW'(2);
        wr_addr  = AW'(6);
        wr_data  = 8'h66;
        wr_valid = 1'b1;
        #1;
        chk("s2_ready_blocked", wr_ready, 0);
        tick();
        vid_req = 1'b0;
        #1;
        chk("s2_ready_free", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        vid_read("s2_read", 6, 'h66);

        host_write(12, 'h99);
        vid_read("oor_read", 12, 'h00);

        d0 = done_cnt;
        start_cmd(1'b1, 1'b0, 'h20);
        chk("s3_busy", busy, 1);
        wait_idle(1'b0, n);
        chk("s3_busy_cycles", n, 9);
        chk("s3_done_pulses", done_cnt - d0, 1);
        for (int i = 0; i < DEPTH; i++) vid_read("s3_read", i, 'h20);

        for (int pass = 0; pass < 2; pass++) begin
            preload('h10);
            start_cmd(1'b0, 1'b1, 'h20);
            wait_idle(pass == 1, n);
            for (int i = 0; i < DEPTH; i++) begin
                exp = !SCROLL ? 'h10 + i : (i < COLS) ? 'h14 + i : 'h20;
                vid_read("s4_read", i, exp);
            end
        end

        d0 = done_cnt;
        start_cmd(1'b1, 1'b1, 'h33);
        tick();
        start_cmd(1'b0, 1'b1, 'h44);
        wait_idle(1'b0, n);
        repeat (4) tick();
        chk("s5_done_pulses", done_cnt - d0, 1);
        for (int i = 0; i < DEPTH; i++) vid_read("s5_read", i, 'h33);

        preload('h50);
        d0 = done_cnt;
        start_cmd(1'b1, 1'b0, 'hAA);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("s6_busy", busy, 0);
        repeat (3) tick();
        chk("s6_no_done", done_cnt - d0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            exp = (i < 3) ? 'hAA : 'h50 + i;
            vid_read("s6_read", i, exp);
        end

        for (int c = 0; c < 3000; c++) begin
            vid_req    = ($urandom_range(0, 2) == 0);
            vid_addr   = AW'($urandom_range(0, 15));
            wr_valid   = 1'($urandom_range(0, 1));
            wr_addr    = AW'($urandom_range(0, 15));
            wr_data    = DW'($urandom);
            cmd_clear  = ($urandom_range(0, 40) == 0);
            cmd_scroll = ($urandom_range(0, 30) == 0);
            fill_char  = DW'($urandom);
            reset      = ($urandom_range(0, 300) != 0);
            tick();
        end
        vid_req = 1'b0;
        wr_valid = 1'b0;
        cmd_clear = 1'b0;
        cmd_scroll = 1'b0;
        reset = 1'b1;
        repeat (60) tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
